// File: rtl/avalon_read_responder.sv
// Avalon-MM pipelined-read slave backed by a small register memory.
// Fixed read latency, bounded outstanding reads, sticky protocol error flag.
module avalon_read_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int LATENCY  = 2,
    parameter int MAX_PEND = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [DATA_W-1:0] slave_writedata,
    input  logic              stall,
    output logic              slave_waitrequest,
    output logic [DATA_W-1:0] slave_readdata,
    output logic              slave_readdatavalid,
    output logic [3:0]        pending,
    output logic              protocol_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [DATA_W-1:0]  dat_q [LATENCY];
    logic [DATA_W-1:0]  dat_d [LATENCY];
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [3:0]         pend_q, pend_d;
    logic               err_q, err_d;
    logic               ret, rd_acc, wr_acc;

    always_comb begin
        ret               = vld_q[LATENCY-1];
        // A return frees a slot in the same cycle, so a full pipe can still accept.
        slave_waitrequest = reset | stall | ((pend_q == 4'(MAX_PEND)) & ~ret);
        rd_acc            = slave_read & ~slave_write & ~slave_waitrequest;
        wr_acc            = slave_write & ~slave_read & ~slave_waitrequest;

        vld_d    = vld_q;
        vld_d[0] = rd_acc;
        dat_d    = dat_q;
        dat_d[0] = mem_q[slave_address];
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end

        // Output register only loads on a returning word, so it holds otherwise.
        rdata_d = vld_d[LATENCY-1] ? dat_d[LATENCY-1] : rdata_q;

        pend_d = pend_q;
        case ({rd_acc, ret})
            2'b10:   pend_d = pend_q + 4'd1;
            2'b01:   pend_d = pend_q - 4'd1;
            default: pend_d = pend_q;
        endcase

        err_d = err_q | (slave_read & slave_write & ~slave_waitrequest);

        mem_d = mem_q;
        if (wr_acc) begin
            mem_d[slave_address] = slave_writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
            vld_q   <= '0;
            rdata_q <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Synchronous reset only clears flops at the edge; mask outputs during the reset cycle too.
    assign slave_readdatavalid = ret & ~reset;
    assign slave_readdata      = reset ? '0 : rdata_q;
    assign pending             = reset ? 4'd0 : pend_q;
    assign protocol_err        = err_q & ~reset;

endmodule

// File: tb/tb_avalon_read_responder.sv
// Bench for avalon_read_responder: two configurations share one stimulus stream and
// are checked against a return-time queue model, plus a constant vector table.
module tb_avalon_read_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        stall = 1'b0;

    logic        wait_a, valid_a, err_a, wait_b, valid_b, err_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  pend_a, pend_b;

    always #5 clk = ~clk;

    avalon_read_responder #(.DATA_W(32), .ADDR_W(4), .LATENCY(2), .MAX_PEND(4)) dut_a (
        .clk(clk), .reset(reset), .slave_address(slave_address), .slave_read(slave_read),
        .slave_write(slave_write), .slave_writedata(slave_writedata), .stall(stall),
        .slave_waitrequest(wait_a), .slave_readdata(data_a), .slave_readdatavalid(valid_a),
        .pending(pend_a), .protocol_err(err_a));

    avalon_read_responder #(.DATA_W(32), .ADDR_W(4), .LATENCY(8), .MAX_PEND(2)) dut_b (
        .clk(clk), .reset(reset), .slave_address(slave_address), .slave_read(slave_read),
        .slave_write(slave_write), .slave_writedata(slave_writedata), .stall(stall),
        .slave_waitrequest(wait_b), .slave_readdata(data_b), .slave_readdatavalid(valid_b),
        .pending(pend_b), .protocol_err(err_b));

    int checks = 0;
    int errors = 0;
    longint cyc = 0;

    // Model: each outstanding read is a (due cycle, data) entry; memory is a plain array.
    typedef struct {
        longint      due;
        logic [31:0] d;
    } ent_t;

    ent_t        mq   [2][$];
    logic [31:0] mm   [2][16];
    logic [31:0] last [2];
    logic        merr [2];
    int          lat  [2] = '{2, 8};
    int          maxp [2] = '{4, 2};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rd, input logic wr, input logic [3:0] a,
                        input logic [31:0] wd, input logic st, input logic rs);
        logic        e_valid, e_wait, acc;
        logic [31:0] e_data;
        logic [31:0] aw, ad, ap;
        logic        av, ae;
        string       px;
        @(negedge clk);
        slave_read = rd; slave_write = wr; slave_address = a;
        slave_writedata = wd; stall = st; reset = rs;
        #1;
        for (int i = 0; i < 2; i++) begin
            px = (i == 0) ? "a" : "b";
            aw = (i == 0) ? 32'(wait_a)  : 32'(wait_b);
            av = (i == 0) ? valid_a : valid_b;
            ad = (i == 0) ? data_a  : data_b;
            ap = (i == 0) ? 32'(pend_a) : 32'(pend_b);
            ae = (i == 0) ? err_a   : err_b;
            e_valid = !rs && mq[i].size() > 0 && mq[i][0].due == cyc;
            e_data  = rs ? 32'd0 : (e_valid ? mq[i][0].d : last[i]);
            e_wait  = rs || st || (mq[i].size() == maxp[i] && !e_valid);
            chk({px, "_valid"}, 32'(av), 32'(e_valid));
            chk({px, "_data"},  ad, e_data);
            chk({px, "_pend"},  ap, rs ? 32'd0 : 32'(mq[i].size()));
            chk({px, "_err"},   32'(ae), rs ? 32'd0 : 32'(merr[i]));
            chk({px, "_wait"},  aw, 32'(e_wait));
            if (rs) begin
                mq[i].delete();
                for (int k = 0; k < 16; k++) mm[i][k] = '0;
                last[i] = '0;
                merr[i] = 1'b0;
            end else begin
                if (e_valid) begin
                    last[i] = mq[i][0].d;
                    void'(mq[i].pop_front());
                end
                acc = rd && !wr && !e_wait;
                if (acc) mq[i].push_back('{cyc + lat[i], mm[i][a]});
                if (wr && !rd && !e_wait) mm[i][a] = wd;
                if (wr && rd && !e_wait) merr[i] = 1'b1;
            end
        end
        cyc++;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [3:0]  a;
        logic [31:0] wd;
        logic        st, rs;
        logic        e_wait, e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_pend;
        logic        e_err;
    } vec_t;

    vec_t tv [11];

    initial begin
        logic [31:0] got [$];
        int          n_wait, acc, maxb;

        // Write/read-back, hold of readdata, then a read+write collision.
        tv[0]  = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         4'd0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 4'd3, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 4'd3, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         4'd0, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         4'd1, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 4'd1, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 4'd0, 1'b0};
        tv[6]  = '{1'b1, 1'b1, 4'd3, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 4'd0, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 4'd3, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 4'd0, 1'b1};
        tv[8]  = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 4'd1, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 4'd1, 1'b1};
        tv[10] = '{1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 4'd0, 1'b1};

        for (int t = 0; t < 11; t++) begin
            step(tv[t].rd, tv[t].wr, tv[t].a, tv[t].wd, tv[t].st, tv[t].rs);
            chk("tv_wait",  32'(wait_a),  32'(tv[t].e_wait));
            chk("tv_valid", 32'(valid_a), 32'(tv[t].e_valid));
            chk("tv_data",  data_a,       tv[t].e_data);
            chk("tv_pend",  32'(pend_a),  32'(tv[t].e_pend));
            chk("tv_err",   32'(err_a),   32'(tv[t].e_err));
        end

        // Five back-to-back reads on the LATENCY=2 / MAX_PEND=4 config.
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, k[3:0], 32'h100 + k, 1'b0, 1'b0);
        n_wait = 0;
        for (int k = 0; k < 9; k++) begin
            if (k < 5) step(1'b1, 1'b0, k[3:0], 32'h0, 1'b0, 1'b0);
            else       step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
            if (k < 5 && wait_a) n_wait++;
            if (valid_a) got.push_back(data_a);
            if (k == 2 || k == 6) chk("b2b_valid_window", 32'(valid_a), 32'd1);
        end
        chk("b2b_waits", n_wait, 0);
        chk("b2b_count", got.size(), 5);
        for (int k = 0; k < 5 && k < got.size(); k++) chk("b2b_order", got[k], 32'h100 + k);

        // Stall held for three cycles with a read pending.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'd1, 32'h0, 1'b1, 1'b0);
            chk("stall_wait", 32'(wait_a), 32'd1);
        end
        step(1'b1, 1'b0, 4'd1, 32'h0, 1'b0, 1'b0);
        chk("stall_release", 32'(wait_a), 32'd0);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        chk("stall_early", 32'(valid_a), 32'd0);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        chk("stall_valid", 32'(valid_a), 32'd1);
        chk("stall_data",  data_a, 32'h101);

        // LATENCY=8 / MAX_PEND=2: third read is held until the first return.
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        acc = 0; maxb = 0;
        for (int k = 0; k < 40 && acc < 3; k++) begin
            step(1'b1, 1'b0, 4'(acc), 32'h0, 1'b0, 1'b0);
            if (int'(pend_b) > maxb) maxb = int'(pend_b);
            if (!wait_b) begin
                acc++;
                if (acc == 3) chk("l8_third_on_return", 32'(valid_b), 32'd1);
            end
        end
        chk("l8_accepts", acc, 3);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
            if (int'(pend_b) > maxb) maxb = int'(pend_b);
        end
        chk("l8_maxpend_le2", 32'(maxb <= 2), 32'd1);

        // Reset with reads in flight, then memory reads back zero.
        step(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd5, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd5, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
            chk("rst_no_valid_a", 32'(valid_a), 32'd0);
            chk("rst_no_valid_b", 32'(valid_b), 32'd0);
        end
        chk("rst_pend", 32'(pend_a), 32'd0);
        step(1'b1, 1'b0, 4'd5, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        chk("rst_mem_valid", 32'(valid_a), 32'd1);
        chk("rst_mem_zero",  data_a, 32'h0);

        // Random traffic, both configurations checked by the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 25,
                 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 299) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
